// File: rtl/traffic_light_controller_if.sv
// traffic_light_controller_if
// Purpose: bundles the loop-sensor inputs and the six lamp outputs of one
//          intersection so they travel as a single port.
// Signals:
//   NS_VEHICLE_DETECT  north-south loop sensor, level, synchronous to clk
//   EW_VEHICLE_DETECT  east-west loop sensor, level, synchronous to clk
//   NS_RED/NS_YELLOW/NS_GREEN  north-south lamps (registered in the controller)
//   EW_RED/EW_YELLOW/EW_GREEN  east-west lamps (registered in the controller)
// Modports:
//   master  roadside side: drives the sensors, observes the lamps
//   slave   controller side: reads the sensors, drives the lamps
interface traffic_light_controller_if;
  logic NS_VEHICLE_DETECT;
  logic EW_VEHICLE_DETECT;
  logic NS_RED;
  logic NS_YELLOW;
  logic NS_GREEN;
  logic EW_RED;
  logic EW_YELLOW;
  logic EW_GREEN;

  modport master (
    output NS_VEHICLE_DETECT,
    output EW_VEHICLE_DETECT,
    input  NS_RED,
    input  NS_YELLOW,
    input  NS_GREEN,
    input  EW_RED,
    input  EW_YELLOW,
    input  EW_GREEN
  );

  modport slave (
    input  NS_VEHICLE_DETECT,
    input  EW_VEHICLE_DETECT,
    output NS_RED,
    output NS_YELLOW,
    output NS_GREEN,
    output EW_RED,
    output EW_YELLOW,
    output EW_GREEN
  );
endinterface

// File: rtl/traffic_light_controller.sv
// traffic_light_controller
// Purpose: two-road traffic light controller. The north-south main road rests
//          on green and yields to the east-west side road only once an EW
//          vehicle has been seen and the NS minimum green has run out. EW green
//          is extended for as long as EW traffic keeps coming and NS is empty.
// Parameters:
//   TICK_DIV      clock cycles per one-second tick (>= 1)
//   NS_MIN_GREEN  NS minimum green, in ticks
//   EW_GREEN      EW base green, in ticks
//   YELLOW        yellow duration, in ticks
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  slave side of traffic_light_controller_if (sensors in, lamps out)
// Configuration:
//   TRAFFIC_ALL_RED_EN  when defined, a one-tick all-red clearance phase is
//                       inserted after each yellow, before the opposing green.
module traffic_light_controller #(
  parameter int TICK_DIV     = 1,
  parameter int NS_MIN_GREEN = 32,
  parameter int EW_GREEN     = 16,
  parameter int YELLOW       = 4
) (
  input logic                       clk,
  input logic                       rst,
  traffic_light_controller_if.slave bus
);

  // One shared phase counter sized for the longest phase.
  localparam int MAX_A = (NS_MIN_GREEN > EW_GREEN) ? NS_MIN_GREEN : EW_GREEN;
  localparam int MAX_T = (MAX_A > YELLOW) ? MAX_A : YELLOW;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] NS_LAST  = CNT_W'(NS_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] EW_LAST  = CNT_W'(EW_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW - 1);

  // Lamp encoding per direction: {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_G      = 3'd0,
    NS_Y      = 3'd1,
    EW_G      = 3'd2,
    EW_Y      = 3'd3,
    RED_TO_EW = 3'd4,
    RED_TO_NS = 3'd5
  } state_t;

`ifdef TRAFFIC_ALL_RED_EN
  localparam state_t AFTER_NS_Y = RED_TO_EW;
  localparam state_t AFTER_EW_Y = RED_TO_NS;
`else
  localparam state_t AFTER_NS_Y = EW_G;
  localparam state_t AFTER_EW_Y = NS_G;
`endif

  state_t           state;
  state_t           next_state;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_limit;
  logic             ew_req;
  logic [2:0]       ns_lamp_next;
  logic [2:0]       ew_lamp_next;
  logic [2:0]       ns_lamp;
  logic [2:0]       ew_lamp;

  // Free-running prescaler; with TICK_DIV=1 it sits at 0 and tick is constant.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NS_G;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. NS leaves green only at the saturated minimum with a
  // pending EW request (latched or live); EW green stays extended while EW is
  // still occupied and NS is empty.
  always_comb begin
    next_state = state;
    case (state)
      NS_G: begin
        if (tick && (phase_cnt == NS_LAST) && (ew_req || bus.EW_VEHICLE_DETECT)) begin
          next_state = NS_Y;
        end
      end
      NS_Y: begin
        if (tick && (phase_cnt == Y_LAST)) begin
          next_state = AFTER_NS_Y;
        end
      end
      EW_G: begin
        if (tick && (phase_cnt == EW_LAST) &&
            (bus.NS_VEHICLE_DETECT || !bus.EW_VEHICLE_DETECT)) begin
          next_state = EW_Y;
        end
      end
      EW_Y: begin
        if (tick && (phase_cnt == Y_LAST)) begin
          next_state = AFTER_EW_Y;
        end
      end
`ifdef TRAFFIC_ALL_RED_EN
      RED_TO_EW: begin
        if (tick) begin
          next_state = EW_G;
        end
      end
      RED_TO_NS: begin
        if (tick) begin
          next_state = NS_G;
        end
      end
`endif
      default: next_state = NS_G;
    endcase
  end

  // Greens saturate at their last count so they can wait there indefinitely;
  // other phases always leave when they reach their limit.
  always_comb begin
    phase_limit = Y_LAST;
    case (state)
      NS_G:    phase_limit = NS_LAST;
      EW_G:    phase_limit = EW_LAST;
      default: phase_limit = Y_LAST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
    end else if (next_state != state) begin
      phase_cnt <= '0;
    end else if (tick && (phase_cnt != phase_limit)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // EW request latch: a single-cycle detect anywhere in NS green is held until
  // NS yellow starts. Clearing wins over a detect in the transition cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ew_req <= 1'b0;
    end else if ((state == NS_G) && (next_state == NS_Y)) begin
      ew_req <= 1'b0;
    end else if ((state == NS_G) && bus.EW_VEHICLE_DETECT) begin
      ew_req <= 1'b1;
    end
  end

  // Lamp decode from the upcoming state so the registered lamps change on the
  // same edge that commits the state change.
  always_comb begin
    ns_lamp_next = LAMP_RED;
    ew_lamp_next = LAMP_RED;
    case (next_state)
      NS_G:    ns_lamp_next = LAMP_GREEN;
      NS_Y:    ns_lamp_next = LAMP_YELLOW;
      EW_G:    ew_lamp_next = LAMP_GREEN;
      EW_Y:    ew_lamp_next = LAMP_YELLOW;
      default: begin
        ns_lamp_next = LAMP_RED;
        ew_lamp_next = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ns_lamp <= LAMP_GREEN;
      ew_lamp <= LAMP_RED;
    end else begin
      ns_lamp <= ns_lamp_next;
      ew_lamp <= ew_lamp_next;
    end
  end

  assign bus.NS_RED    = ns_lamp[2];
  assign bus.NS_YELLOW = ns_lamp[1];
  assign bus.NS_GREEN  = ns_lamp[0];
  assign bus.EW_RED    = ew_lamp[2];
  assign bus.EW_YELLOW = ew_lamp[1];
  assign bus.EW_GREEN  = ew_lamp[0];

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller
// Purpose: self-checking bench for traffic_light_controller. Two instances
//          share clock, reset and detector stimulus: one with TICK_DIV=1 and
//          one with TICK_DIV=4. Lamps are read as {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G}.
//          Expectations follow the all-red option when TRAFFIC_ALL_RED_EN is set.
module tb_traffic_light_controller;

  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;
  localparam logic [5:0] L_RED = 6'b100_100;

`ifdef TRAFFIC_ALL_RED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  typedef struct {
    int         cycle;
    bit         slow;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_light_controller_if bus1 ();
  traffic_light_controller_if bus4 ();

  traffic_light_controller #(
    .TICK_DIV(1), .NS_MIN_GREEN(32), .EW_GREEN(16), .YELLOW(4)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  traffic_light_controller #(
    .TICK_DIV(4), .NS_MIN_GREEN(32), .EW_GREEN(16), .YELLOW(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  logic [5:0] lamps1;
  logic [5:0] lamps4;
  assign lamps1 = {bus1.NS_RED, bus1.NS_YELLOW, bus1.NS_GREEN,
                   bus1.EW_RED, bus1.EW_YELLOW, bus1.EW_GREEN};
  assign lamps4 = {bus4.NS_RED, bus4.NS_YELLOW, bus4.NS_GREEN,
                   bus4.EW_RED, bus4.EW_YELLOW, bus4.EW_GREEN};

  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  int         toggles1   = 0;
  int         toggles4   = 0;
  int         bad_combo  = 0;
  logic [5:0] prev1;
  logic [5:0] prev4;
  vec_t       vecs[$];

  function automatic bit legal(input logic [5:0] l);
    return $onehot(l[5:3]) && $onehot(l[2:0]) && (l[5] || l[2]);
  endfunction

  task automatic applyStimulus(input logic ns, input logic ew);
    bus1.NS_VEHICLE_DETECT = ns;
    bus1.EW_VEHICLE_DETECT = ew;
    bus4.NS_VEHICLE_DETECT = ns;
    bus4.EW_VEHICLE_DETECT = ew;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] actual,
                             input logic [5:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: lamps=%b expected=%b (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (lamps1 !== prev1) toggles1++;
    if (lamps4 !== prev4) toggles4++;
    prev1 = lamps1;
    prev4 = lamps4;
    if (!legal(lamps1) || !legal(lamps4)) bad_combo++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  // Reset edge; afterwards the bench sits in cycle 0 of the fresh NS green.
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    prev1 = lamps1;
    prev4 = lamps4;
    toggles1 = 0;
    toggles4 = 0;
  endtask

  task automatic addVec(input int c, input bit s, input logic [5:0] e);
    vec_t v;
    v.cycle = c;
    v.slow  = s;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  initial begin
    int t;
    int t0;

    // Sustained demand checkpoints, ascending cycle order.
    addVec(0,          1'b0, L_NSG);
    addVec(0,          1'b1, L_NSG);
    addVec(31,         1'b0, L_NSG);
    addVec(32,         1'b0, L_NSY);
    addVec(35,         1'b0, L_NSY);
    addVec(36,         1'b0, (AR != 0) ? L_RED : L_EWG);
    addVec(36 + AR,    1'b0, L_EWG);
    addVec(51 + AR,    1'b0, L_EWG);
    addVec(52 + AR,    1'b0, L_EWY);
    addVec(55 + AR,    1'b0, L_EWY);
    addVec(56 + AR,    1'b0, (AR != 0) ? L_RED : L_NSG);
    addVec(56 + 2*AR,  1'b0, L_NSG);
    addVec(87 + 2*AR,  1'b0, L_NSG);
    addVec(88 + 2*AR,  1'b0, L_NSY);
    addVec(127,        1'b1, L_NSG);
    addVec(128,        1'b1, L_NSY);
    addVec(143,        1'b1, L_NSY);
    addVec(144,        1'b1, (AR != 0) ? L_RED : L_EWG);
    addVec(147,        1'b1, (AR != 0) ? L_RED : L_EWG);
    addVec(148,        1'b1, L_EWG);
    addVec(207 + 4*AR, 1'b1, L_EWG);
    addVec(208 + 4*AR, 1'b1, L_EWY);
    addVec(223 + 4*AR, 1'b1, L_EWY);
    addVec(224 + 4*AR, 1'b1, (AR != 0) ? L_RED : L_NSG);
    addVec(224 + 8*AR, 1'b1, L_NSG);

    applyStimulus(1'b0, 1'b0);

    // No traffic: NS stays green, nothing toggles.
    doReset();
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_state_div1", lamps1, L_NSG);
    checkOutput("reset_state_div4", lamps4, L_NSG);
    runTo(10000);
    checkCount("quiet_toggles_div1", toggles1, 0);
    checkCount("quiet_toggles_div4", toggles4, 0);
    checkOutput("quiet_final_div1", lamps1, L_NSG);
    checkOutput("quiet_final_div4", lamps4, L_NSG);

    // Sustained demand on both roads, table-driven.
    doReset();
    applyStimulus(1'b1, 1'b1);
    foreach (vecs[i]) begin
      runTo(vecs[i].cycle);
      checkOutput($sformatf("sustain_%s_c%0d", vecs[i].slow ? "div4" : "div1", vecs[i].cycle),
                  vecs[i].slow ? lamps4 : lamps1, vecs[i].exp);
    end

    // Single-cycle EW pulse in NS green, then EW activity only during yellow.
    doReset();
    applyStimulus(1'b0, 1'b0);
    runTo(5);
    applyStimulus(1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
    runTo(31);
    checkOutput("latch_ns_green_end", lamps1, L_NSG);
    runTo(32);
    checkOutput("latch_ns_yellow", lamps1, L_NSY);
    runTo(36 + AR);
    checkOutput("latch_ew_green", lamps1, L_EWG);
    runTo(51 + AR);
    checkOutput("latch_ew_green_end", lamps1, L_EWG);
    runTo(52 + AR);
    checkOutput("latch_ew_yellow", lamps1, L_EWY);
    applyStimulus(1'b0, 1'b1);
    runTo(55 + AR);
    checkOutput("latch_ew_yellow_end", lamps1, L_EWY);
    step();
    applyStimulus(1'b0, 1'b0);
    runTo(56 + 2*AR);
    checkOutput("latch_back_ns", lamps1, L_NSG);
    t0 = toggles1;
    runTo(56 + 2*AR + 200);
    checkCount("latch_ns_holds_toggles", toggles1 - t0, 0);
    checkOutput("latch_ns_holds", lamps1, L_NSG);

    // EW extension while NS is empty, ended by an NS arrival.
    doReset();
    applyStimulus(1'b0, 1'b1);
    runTo(36 + AR);
    checkOutput("ext_ew_green", lamps1, L_EWG);
    t = 76 + AR;
    runTo(t);
    checkOutput("ext_held_past_base", lamps1, L_EWG);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ext_ns_arrives", lamps1, L_EWG);
    step();
    checkOutput("ext_ew_yellow", lamps1, L_EWY);
    runTo(t + 4);
    checkOutput("ext_ew_yellow_end", lamps1, L_EWY);
    runTo(t + 5);
    checkOutput("ext_after_yellow", lamps1, (AR != 0) ? L_RED : L_NSG);
    runTo(t + 5 + AR);
    checkOutput("ext_ns_green", lamps1, L_NSG);

    // Reset in the middle of EW green restarts a full NS minimum green.
    doReset();
    applyStimulus(1'b1, 1'b1);
    runTo(40 + AR);
    checkOutput("midreset_pre_ew_green", lamps1, L_EWG);
    doReset();
    checkOutput("midreset_ns_green", lamps1, L_NSG);
    runTo(31);
    checkOutput("midreset_full_min_green", lamps1, L_NSG);
    runTo(32);
    checkOutput("midreset_ns_yellow", lamps1, L_NSY);

    checkCount("illegal_lamp_cycles", bad_combo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
